mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one 32-bit external memory port between the instruction-cache refill path and the data-cache refill/writeback path. Each requester issues whole 128-bit line transactions. The block arbitrates round-robin, serializes each line into four 32-bit beats, and reassembles read beats into a line. It sits between the two cache controllers and the memory interface, below the fetch stage.

## Interface
- ADDR_WIDTH, 32, byte address width on all ports
- LINE_WIDTH, 128, cache line width; fixed at 4 × MEM_WIDTH
- MEM_WIDTH, 32, memory data width

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- ic_addr  in  ADDR_WIDTH  icache line address; bits [3:0] ignored
- ic_rd  in  1  icache line read request
- ic_readdata  out  LINE_WIDTH  assembled line
- ic_waitrequest  out  1  low for exactly one cycle when the ic transaction completes
- dc_addr  in  ADDR_WIDTH  dcache line address; bits [3:0] ignored
- dc_rd  in  1  dcache line read request
- dc_wr  in  1  dcache line write request
- dc_wdata  in  LINE_WIDTH  line to write; word0 is in [127:96]
- dc_readdata  out  LINE_WIDTH  assembled line
- dc_waitrequest  out  1  low for exactly one cycle when the dc transaction completes
- mem_addr  out  ADDR_WIDTH  beat address, word aligned
- mem_rd  out  1  beat read command
- mem_wr  out  1  beat write command
- mem_wdata  out  MEM_WIDTH  beat write data
- mem_rdata  in  MEM_WIDTH  read data, valid in the cycle the beat is accepted
- mem_waitrequest  in  1  beat stalled while high

## Operation
- States: IDLE, BEAT, DONE.
- IDLE:
  - Sample ic_req = ic_rd and dc_req = dc_rd|dc_wr.
  - One requester: grant it. Both: grant the one not in last_grant.
  - Latch grant, line base addr[31:4], op (write if dc_wr) and wdata. Clear beat counter. Go to BEAT.
  - No request: stay in IDLE.
- BEAT:
  - Drive mem_addr = {base, beat[1:0], 2'b00}.
  - Drive mem_rd or mem_wr for the whole state.
  - Drive mem_wdata = word[beat] of the latched line; word0 is [127:96].
  - A beat is accepted when its command is high and mem_waitrequest is low.
  - On a read accept, write mem_rdata into line buffer word[beat].
  - After each accept, increment beat. On the accept of beat 3, go to DONE.
- DONE:
  - Drop the granted master's waitrequest for one cycle. Hold the line buffer on both readdata ports.
  - Set last_grant to the granted master. Go to IDLE.
- Waitrequest of a master is 1 in every cycle except its own DONE cycle.
- ic_readdata and dc_readdata both mirror the line buffer. The buffer changes only on read accepts, and write transactions leave it untouched.
- dc_rd and dc_wr both high: treated as a write.
- Protocol rule: a master holds its request, address and wdata stable until it sees waitrequest low. Deasserting early is illegal; the arbiter completes the latched transaction regardless.

## Timing
- Reset values:
  - state IDLE; last_grant = DC, so IC wins the first tie.
  - ic_waitrequest = dc_waitrequest = 1.
  - mem_rd = mem_wr = 0; mem_addr, mem_wdata, line buffer and both readdata ports = 0.
- Outputs are registered or decoded from registered state; there is no combinational path from mem_* inputs to mem_* outputs.
- With the request sampled at cycle N and no memory stall:
  - beats occupy cycles N+1 to N+4;
  - DONE is at N+5, with waitrequest low for that cycle;
  - IDLE is at N+6, where a new request can be sampled.
- Minimum service latency is 5 cycles. Each stall cycle adds one.
- Beat address wraps within the line: beat is 2 bits and base bits do not change.
- A request arriving during BEAT or DONE waits; it is sampled in the next IDLE.
- Reset asserted mid-transaction: all state returns to reset values immediately. mem_rd and mem_wr fall asynchronously, and the partial line is discarded.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE, BEAT, DONE), master id enum (MST_IC, MST_DC), BEATS = LINE_WIDTH/MEM_WIDTH.
- One sub-module arb2_rr: two-input round-robin grant holding last_grant, with an update strobe from DONE.
- Beat serializer and line buffer stay in the top module.

## Test plan
- IC read of 0x0000_1234 alone, mem_waitrequest = 0, memory returns 0xA0,0xA1,0xA2,0xA3 → mem_addr 0x1230,0x1234,0x1238,0x123C on N+1..N+4; ic_waitrequest low at N+5; ic_readdata = {A0,A1,A2,A3}.
- DC write of 0x0000_2000, wdata {11,22,33,44} → four mem_wr beats to 0x2000–0x200C with data 11,22,33,44 in order; dc_waitrequest low one cycle; line buffer unchanged.
- IC and DC requests in the same cycle after reset → IC is served first; DC starts in the IDLE cycle after IC's DONE; a second simultaneous pair is served DC first.
- mem_waitrequest high for 3 cycles on beat 2 → mem_addr and mem_rd held during the stall; waitrequest goes low at N+8.
- reset pulsed during beat 1 of a DC read → mem_rd = 0 and both waitrequests = 1 immediately; after release, a fresh IC request completes normally in 5 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master line-transaction memory arbiter.
package mem_arb_pkg;
  localparam int PKG_LINE_WIDTH = 128;
  localparam int PKG_MEM_WIDTH  = 32;
  localparam int BEATS          = PKG_LINE_WIDTH / PKG_MEM_WIDTH;

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_e;
  typedef enum logic {MST_IC, MST_DC} mst_e;
endpackage

// File: rtl/mem_arbiter_arb2_rr.sv
// Two-input round-robin grant; the last served master loses the next tie.
module arb2_rr
  import mem_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_ic,
  input  logic req_dc,
  input  logic update,
  input  mst_e upd_master,
  output logic grant_valid,
  output mst_e grant
);

  mst_e last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (update) begin
      last_grant_d = upd_master;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= MST_DC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    grant_valid = req_ic | req_dc;
    grant       = MST_IC;
    if (req_ic && req_dc) begin
      grant = (last_grant_q == MST_DC) ? MST_IC : MST_DC;
    end else if (req_dc) begin
      grant = MST_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 32-bit memory port between icache refill and dcache refill/writeback,
// serializing 128-bit lines into four word beats and reassembling read lines.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int MEM_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic                  ic_rd,
  output logic [LINE_WIDTH-1:0] ic_readdata,
  output logic                  ic_waitrequest,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic                  dc_rd,
  input  logic                  dc_wr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic [LINE_WIDTH-1:0] dc_readdata,
  output logic                  dc_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  input  logic [MEM_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_waitrequest
);

  state_e                  state_q, state_d;
  mst_e                    grant_q, grant_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-5:0]   base_q, base_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              beat_q, beat_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;

  logic                    arb_valid;
  mst_e                    arb_grant;
  logic                    accept;
  logic [MEM_WIDTH-1:0]    wword [BEATS];

  arb2_rr u_arb (
    .clock       (clock),
    .reset       (reset),
    .req_ic      (ic_rd),
    .req_dc      (dc_rd | dc_wr),
    .update      (state_q == DONE),
    .upd_master  (grant_q),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  // Word 0 of a line lives in the most significant bits.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_wword
    assign wword[gi] = wdata_q[LINE_WIDTH-1-gi*MEM_WIDTH -: MEM_WIDTH];
  end

  assign accept = (state_q == BEAT) && !mem_waitrequest;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          wr_d    = (arb_grant == MST_DC) && dc_wr;
          base_d  = (arb_grant == MST_DC) ? dc_addr[ADDR_WIDTH-1:4] : ic_addr[ADDR_WIDTH-1:4];
          wdata_d = dc_wdata;
          beat_d  = 2'd0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (accept) begin
          if (!wr_q) begin
            line_d[LINE_WIDTH-1-int'(beat_q)*MEM_WIDTH -: MEM_WIDTH] = mem_rdata;
          end
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= MST_IC;
      wr_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      beat_q  <= 2'd0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

  // Outputs decode registered state only, so reset drops the commands at once.
  assign mem_addr       = {base_q, beat_q, 2'b00};
  assign mem_rd         = (state_q == BEAT) && !wr_q;
  assign mem_wr         = (state_q == BEAT) && wr_q;
  assign mem_wdata      = wword[beat_q];
  assign ic_readdata    = line_q;
  assign dc_readdata    = line_q;
  assign ic_waitrequest = !((state_q == DONE) && (grant_q == MST_IC));
  assign dc_waitrequest = !((state_q == DONE) && (grant_q == MST_DC));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of grant order, beats and latency.
module tb_mem_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  ic_addr, dc_addr, mem_addr, mem_wdata, mem_rdata;
  logic         ic_rd, dc_rd, dc_wr, mem_rd, mem_wr, mem_waitrequest;
  logic         ic_waitrequest, dc_waitrequest;
  logic [127:0] ic_readdata, dc_readdata, dc_wdata;

  mem_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .ic_addr         (ic_addr),
    .ic_rd           (ic_rd),
    .ic_readdata     (ic_readdata),
    .ic_waitrequest  (ic_waitrequest),
    .dc_addr         (dc_addr),
    .dc_rd           (dc_rd),
    .dc_wr           (dc_wr),
    .dc_wdata        (dc_wdata),
    .dc_readdata     (dc_readdata),
    .dc_waitrequest  (dc_waitrequest),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_waitrequest (mem_waitrequest)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: pending requests per master, last winner, expected line buffer.
  bit           ic_p, dc_p, dc_w, dc_both;
  logic [31:0]  ic_a, dc_a;
  logic [127:0] dc_wd;
  bit           last_dc;
  logic [127:0] line_m;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_ic();
    ic_p = 1'b1;
    ic_a = $urandom;
  endtask

  task automatic new_dc();
    dc_p    = 1'b1;
    dc_a    = $urandom;
    dc_w    = $urandom_range(1);
    dc_both = $urandom_range(1);
    dc_wd   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drive_masters();
    ic_rd    = ic_p;
    ic_addr  = ic_p ? ic_a : $urandom;
    dc_rd    = dc_p && (!dc_w || dc_both);
    dc_wr    = dc_p && dc_w;
    dc_addr  = dc_p ? dc_a : $urandom;
    dc_wdata = dc_wd;
  endtask

  // One cycle in IDLE: present requests, check quiet outputs.
  task automatic idle_step(input bit gen);
    @(posedge clock);
    #1;
    if (gen && !ic_p && $urandom_range(2) == 0) new_ic();
    if (gen && !dc_p && $urandom_range(2) == 0) new_dc();
    drive_masters();
    mem_waitrequest = $urandom_range(1);
    mem_rdata       = $urandom;
    @(negedge clock);
    chk("idle_mem_rd", mem_rd, 1'b0);
    chk("idle_mem_wr", mem_wr, 1'b0);
    chk("idle_ic_wait", ic_waitrequest, 1'b1);
    chk("idle_dc_wait", dc_waitrequest, 1'b1);
    chk("idle_readdata", dc_readdata, line_m);
  endtask

  // Serve one line transaction starting right after an IDLE sample.
  task automatic do_txn(input bit gen, input int stall_pct, input int stall_beat,
                        input int stall_len, input bit fixed_data,
                        output int cycles, output bit win_dc);
    bit           wr, stall;
    logic [27:0]  base;
    logic [127:0] wd;
    logic [31:0]  rd;
    int           b, sc, stalls;
    win_dc = dc_p && (!ic_p || !last_dc);
    wr     = win_dc && dc_w;
    base   = win_dc ? dc_a[31:4] : ic_a[31:4];
    wd     = dc_wd;
    b = 0; sc = 0; stalls = 0; cycles = 0;
    while (b < 4 && cycles < 100) begin
      @(posedge clock);
      #1;
      cycles++;
      if (gen && !ic_p && $urandom_range(9) == 0) new_ic();
      if (gen && !dc_p && $urandom_range(9) == 0) new_dc();
      drive_masters();
      if (stall_beat >= 0) stall = (b == stall_beat) && (sc < stall_len);
      else stall = ($urandom_range(99) < stall_pct);
      if (stall_beat >= 0 && stall) sc++;
      rd = fixed_data ? 32'(32'hA0 + b) : $urandom;
      mem_waitrequest = stall;
      mem_rdata       = rd;
      @(negedge clock);
      chk("beat_addr", mem_addr, {base, 2'(b), 2'b00});
      chk("beat_rd", mem_rd, !wr);
      chk("beat_wr", mem_wr, wr);
      if (wr) chk("beat_wdata", mem_wdata, wd[127-32*b -: 32]);
      chk("beat_ic_wait", ic_waitrequest, 1'b1);
      chk("beat_dc_wait", dc_waitrequest, 1'b1);
      if (!stall) begin
        if (!wr) line_m[127-32*b -: 32] = rd;
        b++;
      end else begin
        stalls++;
      end
    end
    chk("beat_count", b, 4);
    @(posedge clock);
    #1;
    cycles++;
    mem_waitrequest = $urandom_range(1);
    mem_rdata       = $urandom;
    @(negedge clock);
    chk("done_ic_wait", ic_waitrequest, win_dc);
    chk("done_dc_wait", dc_waitrequest, !win_dc);
    chk("done_ic_readdata", ic_readdata, line_m);
    chk("done_dc_readdata", dc_readdata, line_m);
    chk("done_mem_rd", mem_rd, 1'b0);
    chk("latency", cycles, 5 + stalls);
    if (win_dc) dc_p = 1'b0;
    else ic_p = 1'b0;
    last_dc = win_dc;
    $display("txn %s %s base=%h cycles=%0d", win_dc ? "DC" : "IC", wr ? "WR" : "RD",
             {base, 4'h0}, cycles);
  endtask

  initial begin
    int cyc;
    bit win;
    int ntx;
    reset = 1'b1;
    ic_p = 0; dc_p = 0; dc_w = 0; dc_both = 0; ic_a = 0; dc_a = 0; dc_wd = 0;
    last_dc = 1'b1;
    line_m  = '0;
    drive_masters();
    mem_waitrequest = 1'b0;
    mem_rdata       = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ic_wait", ic_waitrequest, 1'b1);
    chk("rst_dc_wait", dc_waitrequest, 1'b1);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_ic_readdata", ic_readdata, 128'h0);
    chk("rst_dc_readdata", dc_readdata, 128'h0);
    reset = 1'b0;

    // Lone IC read with known memory data.
    ic_p = 1; ic_a = 32'h0000_1234;
    idle_step(0);
    do_txn(0, 0, -1, 0, 1, cyc, win);
    chk("ic_line", ic_readdata, 128'h000000A0_000000A1_000000A2_000000A3);
    chk("ic_lat5", cyc, 5);

    // DC write leaves the line buffer alone.
    dc_p = 1; dc_a = 32'h0000_2000; dc_w = 1; dc_both = 0;
    dc_wd = 128'h00000011_00000022_00000033_00000044;
    idle_step(0);
    do_txn(0, 0, -1, 0, 0, cyc, win);
    chk("wr_keeps_line", dc_readdata, 128'h000000A0_000000A1_000000A2_000000A3);

    // Simultaneous pair after a DC win: IC first; IC re-requests at once, so DC next.
    ic_p = 1; ic_a = 32'h0000_5000;
    dc_p = 1; dc_a = 32'h0000_6000; dc_w = 0; dc_both = 0;
    idle_step(0);
    do_txn(0, 0, -1, 0, 0, cyc, win);
    chk("tie1_winner", win, 1'b0);
    ic_p = 1; ic_a = 32'h0000_7000;
    idle_step(0);
    do_txn(0, 0, -1, 0, 0, cyc, win);
    chk("tie2_winner", win, 1'b1);
    idle_step(0);
    do_txn(0, 0, -1, 0, 0, cyc, win);
    chk("tie3_winner", win, 1'b0);

    // Three stall cycles on beat 2.
    ic_p = 1; ic_a = 32'h0000_8880;
    idle_step(0);
    do_txn(0, 0, 2, 3, 0, cyc, win);
    chk("stall_lat8", cyc, 8);

    // Random traffic with random stalls.
    ntx = 0;
    for (int t = 0; t < 2000 && (ntx < 40 || ic_p || dc_p); t++) begin
      idle_step(ntx < 40);
      if (ic_p || dc_p) begin
        do_txn(ntx < 40, 25, -1, 0, 0, cyc, win);
        ntx++;
      end
    end
    chk("drained", {ic_p, dc_p}, 2'b00);

    // Reset during beat 1 of a DC read.
    dc_p = 1; dc_a = 32'h0000_3000; dc_w = 0; dc_both = 0;
    idle_step(0);
    @(posedge clock); #1; mem_waitrequest = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("pre_rst_mem_rd", mem_rd, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_rd", mem_rd, 1'b0);
    chk("async_ic_wait", ic_waitrequest, 1'b1);
    chk("async_dc_wait", dc_waitrequest, 1'b1);
    chk("async_line", dc_readdata, 128'h0);
    line_m  = '0;
    last_dc = 1'b1;
    dc_p    = 1'b0;
    drive_masters();
    @(posedge clock); #1;
    reset = 1'b0;
    ic_p = 1; ic_a = 32'h0000_4440;
    idle_step(0);
    do_txn(0, 0, -1, 0, 0, cyc, win);
    chk("post_rst_lat", cyc, 5);
    chk("post_rst_winner", win, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
